// File: rtl/firebird_ifetch_pkg.sv
// Shared constants for the firebird instruction-fetch front end.
//   FIREBIRD_PC_SIZE    : fetch address width
//   FIREBIRD_INST_SIZE  : instruction width
//   FIREBIRD_RESET_ADDR : fetch PC after reset
//   FIREBIRD_PC_STEP    : byte increment between sequential fetches
package firebird_ifetch_pkg;
  localparam int          FIREBIRD_PC_SIZE    = 32;
  localparam int          FIREBIRD_INST_SIZE  = 32;
  localparam logic [31:0] FIREBIRD_RESET_ADDR = 32'h0000_0000;
  localparam int          FIREBIRD_PC_STEP    = 4;
endpackage

// File: rtl/firebird_ifetch_if.sv
// Bundle of the fetch unit's handshake signals.
//   redirect_*  : retarget request from the back end
//   imem_req_*  : request channel to instruction memory (valid/ready)
//   imem_rsp_*  : in-order response channel, no backpressure
//   inst_*      : instruction channel to decode (valid/ready)
// master = fetch unit side, slave = surrounding core / memory side.
interface firebird_ifetch_if
  import firebird_ifetch_pkg::*;
#(
  parameter int PC_W   = FIREBIRD_PC_SIZE,
  parameter int INST_W = FIREBIRD_INST_SIZE
) ();
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_address;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_address;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_address;

  modport master (
    input  redirect_valid, redirect_address, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_address, inst_valid, inst_data, inst_address
  );

  modport slave (
    output redirect_valid, redirect_address, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_address, inst_valid, inst_data, inst_address
  );
endinterface

// File: rtl/firebird_sync_fifo.sv
// Small synchronous FIFO with flush.
//   clk/rst    : clock, synchronous active-high reset
//   push/push_data, pop : enqueue / dequeue (push when full and pop when
//                         empty are ignored)
//   flush      : drop all entries this cycle (wins over push/pop)
//   rd_data    : head entry (valid when !empty)
//   full/empty/count : occupancy
module firebird_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/firebird_ifetch.sv
// Instruction-fetch front end. Owns the fetch PC, issues word-aligned reads
// under a credit limit of FIFO_DEPTH (in-flight + buffered), matches in-order
// responses to their PCs and hands {pc, inst} to decode. A redirect retargets
// the PC, flushes the buffer and arranges for in-flight stale responses to be
// dropped as they return.
//   clk, fetch_reset : clock, synchronous active-high reset
//   bus (master)     : redirect, imem request/response, decode channels
module firebird_ifetch
  import firebird_ifetch_pkg::*;
#(
  parameter int              PC_W       = FIREBIRD_PC_SIZE,
  parameter int              INST_W     = FIREBIRD_INST_SIZE,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_ADDR = PC_W'(FIREBIRD_RESET_ADDR)
) (
  input logic              clk,
  input logic              fetch_reset,
  firebird_ifetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]        r_fetch_pc;
  logic [CW-1:0]          r_outstanding, r_drop_cnt;

  logic [PC_W-1:0]        w_aq_addr, w_redirect_pc;
  logic                   w_aq_full, w_aq_empty;
  logic [CW-1:0]          w_aq_count, w_buf_count;
  logic [PC_W+INST_W-1:0] w_buf_rd;
  logic                   w_buf_full, w_buf_empty;
  logic [CW:0]            w_occ;
  logic                   w_req_valid, w_req_fire, w_rsp_ok, w_rsp_keep;
  logic                   w_inst_valid, w_inst_pop;

  assign w_redirect_pc = bus.redirect_address & ~PC_W'(3);

  // Stale requests still hold credit until their responses drain.
  assign w_occ       = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign w_req_valid = !fetch_reset && !bus.redirect_valid && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok    = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_keep  = w_rsp_ok && (r_drop_cnt == '0) && !bus.redirect_valid;
  assign w_inst_valid = !w_buf_empty && !bus.redirect_valid && !fetch_reset;
  assign w_inst_pop   = w_inst_valid && bus.inst_ready;

  assign bus.imem_req_valid   = w_req_valid;
  assign bus.imem_req_address = r_fetch_pc;
  assign bus.inst_valid       = w_inst_valid;
  assign {bus.inst_address, bus.inst_data} = w_buf_rd;

  // In-flight address queue: not flushed on redirect, since stale responses
  // still return and must pop their entries.
  firebird_sync_fifo #(.WIDTH(PC_W), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk      (clk),
    .rst      (fetch_reset),
    .push     (w_req_fire),
    .push_data(r_fetch_pc),
    .pop      (w_rsp_ok),
    .flush    (1'b0),
    .rd_data  (w_aq_addr),
    .full     (w_aq_full),
    .empty    (w_aq_empty),
    .count    (w_aq_count)
  );

  firebird_sync_fifo #(.WIDTH(PC_W + INST_W), .DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk      (clk),
    .rst      (fetch_reset),
    .push     (w_rsp_keep),
    .push_data({w_aq_addr, bus.imem_rsp_data}),
    .pop      (w_inst_pop),
    .flush    (bus.redirect_valid),
    .rd_data  (w_buf_rd),
    .full     (w_buf_full),
    .empty    (w_buf_empty),
    .count    (w_buf_count)
  );

  always_ff @(posedge clk) begin
    if (fetch_reset) begin
      r_fetch_pc    <= RESET_ADDR;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (bus.redirect_valid)  r_fetch_pc <= w_redirect_pc;
      else if (w_req_fire)     r_fetch_pc <= r_fetch_pc + PC_W'(FIREBIRD_PC_STEP);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
      // Everything still in flight after this cycle belongs to the old stream.
      if (bus.redirect_valid)                    r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
      else if (w_rsp_ok && (r_drop_cnt != '0))   r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (fetch_reset)
    !(bus.imem_rsp_valid && (r_outstanding == '0)));
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (fetch_reset)
    !(w_rsp_keep && w_buf_full));
  a_aq_no_overflow: assert property (@(posedge clk) disable iff (fetch_reset)
    !(w_req_fire && w_aq_full));
  a_aq_tracks_outstanding: assert property (@(posedge clk) disable iff (fetch_reset)
    (w_aq_count == r_outstanding) && (w_aq_empty == (r_outstanding == '0)));
endmodule

// File: tb/tb_firebird_ifetch.sv
module tb_firebird_ifetch;
  import firebird_ifetch_pkg::*;

  logic clk = 1'b0;
  logic fetch_reset = 1'b1;

  firebird_ifetch_if #(.PC_W(32), .INST_W(32)) bus ();

  firebird_ifetch #(.PC_W(32), .INST_W(32), .FIFO_DEPTH(2), .RESET_ADDR(32'h0)) dut (
    .clk        (clk),
    .fetch_reset(fetch_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // stimulus knobs
  logic        rst = 1'b1, redir = 1'b0, irdy = 1'b1;
  logic [31:0] redir_addr = '0;
  bit          rand_rdy = 0, rand_irdy = 0;
  int          lat_lo = 1, lat_hi = 1;

  // memory model: in-order pending reads with their earliest response cycle
  logic [31:0] mq_a[$];
  int          mq_t[$];

  // observations
  logic [31:0] obs_req[$], obs_ia[$], obs_id[$];
  int          fired, consumed, max_occ;
  logic        last_req_valid, last_inst_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic clear_obs();
    obs_req.delete(); obs_ia.delete(); obs_id.delete();
    fired = 0; consumed = 0; max_occ = 0;
  endtask

  // One clock cycle: drive at negedge, sample #1 later, record handshakes.
  task automatic tick();
    logic pres;
    pres = 1'b0;
    if (rst) begin
      mq_a.delete(); mq_t.delete();
    end else if (mq_a.size() > 0 && mq_t[0] <= cyc) begin
      pres = 1'b1;
    end
    bus.imem_rsp_valid = pres;
    if (pres) bus.imem_rsp_data = mem_data(mq_a[0]);
    else      bus.imem_rsp_data = '0;
    bus.imem_req_ready   = rand_rdy  ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.inst_ready       = rand_irdy ? 1'($urandom_range(0, 1)) : irdy;
    bus.redirect_valid   = redir;
    bus.redirect_address = redir_addr;
    fetch_reset          = rst;
    #1;
    last_req_valid  = bus.imem_req_valid;
    last_req_addr   = bus.imem_req_address;
    last_inst_valid = bus.inst_valid;
    if (pres) begin
      void'(mq_a.pop_front()); void'(mq_t.pop_front());
    end
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      obs_req.push_back(bus.imem_req_address);
      mq_a.push_back(bus.imem_req_address);
      mq_t.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
      fired++;
    end
    if (bus.inst_valid && bus.inst_ready) begin
      obs_ia.push_back(bus.inst_address);
      obs_id.push_back(bus.inst_data);
      consumed++;
    end
    if (fired - consumed > max_occ) max_occ = fired - consumed;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_obs();
  endtask

  // Reset, then redirect to 0x10 and run until 0x10 and 0x14 are in flight.
  task automatic setup_two_outstanding(input int lat);
    lat_lo = lat; lat_hi = lat; irdy = 1'b1;
    do_reset();
    redir = 1'b1; redir_addr = 32'h10;
    tick();
    redir = 1'b0;
    clear_obs();
    for (int k = 0; k < 20 && obs_req.size() < 2; k++) tick();
    checks++;
    if (obs_req.size() != 2) begin
      failures++; $display("FAIL setup_reqs got=%0d exp=2", obs_req.size());
    end else begin
      checks++;
      if (obs_req[0] !== 32'h10 || obs_req[1] !== 32'h14) begin
        failures++; $display("FAIL setup_addrs got=%h,%h exp=10,14", obs_req[0], obs_req[1]);
      end
    end
  endtask

  task automatic test_reset();
    rand_rdy = 0; rand_irdy = 0; irdy = 1'b1; lat_lo = 1; lat_hi = 1;
    rst = 1'b1; redir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (last_req_valid !== 1'b0 || last_inst_valid !== 1'b0) begin
        failures++; $display("FAIL reset_outputs req_valid=%b inst_valid=%b exp=0,0", last_req_valid, last_inst_valid);
      end
    end
    rst = 1'b0;
    clear_obs();
    tick();
    checks++;
    if (last_req_valid !== 1'b1 || last_req_addr !== 32'h0) begin
      failures++; $display("FAIL reset_first_req valid=%b addr=%h exp=1,00000000", last_req_valid, last_req_addr);
    end
  endtask

  task automatic test_stream();
    irdy = 1'b1; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 30; k++) tick();
    checks++;
    if (obs_ia.size() < 15) begin
      failures++; $display("FAIL stream_count got=%0d exp>=15", obs_ia.size());
    end
    foreach (obs_ia[i]) begin
      checks++;
      if (obs_ia[i] !== 32'(4 * i) || obs_id[i] !== mem_data(32'(4 * i))) begin
        failures++; $display("FAIL stream_inst[%0d] got=%h/%h exp=%h/%h", i, obs_ia[i], obs_id[i], 32'(4 * i), mem_data(32'(4 * i)));
      end
    end
    foreach (obs_req[i]) begin
      checks++;
      if (obs_req[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_req[%0d] got=%h exp=%h", i, obs_req[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    irdy = 1'b0; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (obs_req.size() != 2) begin
      failures++; $display("FAIL bp_req_count got=%0d exp=2", obs_req.size());
    end else begin
      checks++;
      if (obs_req[0] !== 32'h0 || obs_req[1] !== 32'h4) begin
        failures++; $display("FAIL bp_req_addrs got=%h,%h exp=0,4", obs_req[0], obs_req[1]);
      end
    end
    checks++;
    if (last_req_valid !== 1'b0) begin
      failures++; $display("FAIL bp_req_stalled got=%b exp=0", last_req_valid);
    end
    irdy = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (obs_ia.size() < 3) begin
      failures++; $display("FAIL bp_release_count got=%0d exp>=3", obs_ia.size());
    end
    foreach (obs_ia[i]) begin
      checks++;
      if (obs_ia[i] !== 32'(4 * i) || obs_id[i] !== mem_data(32'(4 * i))) begin
        failures++; $display("FAIL bp_inst[%0d] got=%h exp=%h", i, obs_ia[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    setup_two_outstanding(3);
    clear_obs();
    redir = 1'b1; redir_addr = 32'h203;
    tick();
    checks++;
    if (last_req_valid !== 1'b0 || last_inst_valid !== 1'b0) begin
      failures++; $display("FAIL redir_quiet req_valid=%b inst_valid=%b exp=0,0", last_req_valid, last_inst_valid);
    end
    redir = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (obs_req.size() == 0 || obs_req[0] !== 32'h200) begin
      failures++; $display("FAIL redir_first_req got=%h exp=00000200", obs_req.size() ? obs_req[0] : 32'hx);
    end
    checks++;
    if (obs_ia.size() == 0) begin
      failures++; $display("FAIL redir_no_output got=0 exp>0");
    end
    foreach (obs_ia[i]) begin
      checks++;
      if (obs_ia[i] !== 32'h200 + 32'(4 * i) || obs_id[i] !== mem_data(obs_ia[i])) begin
        failures++; $display("FAIL redir_inst[%0d] got=%h exp=%h", i, obs_ia[i], 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_with_rsp();
    // latency 2 lines the 0x10 response up with the redirect cycle
    setup_two_outstanding(2);
    clear_obs();
    redir = 1'b1; redir_addr = 32'h341;
    tick();
    redir = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (obs_req.size() == 0 || obs_req[0] !== 32'h340) begin
      failures++; $display("FAIL redir_rsp_first_req got=%h exp=00000340", obs_req.size() ? obs_req[0] : 32'hx);
    end
    checks++;
    if (obs_ia.size() == 0 || obs_ia[0] !== 32'h340) begin
      failures++; $display("FAIL redir_rsp_first_inst got=%h exp=00000340", obs_ia.size() ? obs_ia[0] : 32'hx);
    end
    foreach (obs_ia[i]) begin
      checks++;
      if (obs_ia[i] !== 32'h340 + 32'(4 * i) || obs_id[i] !== mem_data(obs_ia[i])) begin
        failures++; $display("FAIL redir_rsp_inst[%0d] got=%h exp=%h", i, obs_ia[i], 32'h340 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    lat_lo = 1; lat_hi = 3;
    do_reset();
    rand_rdy = 1; rand_irdy = 1;
    for (int k = 0; k < 400; k++) tick();
    rand_rdy = 0; rand_irdy = 0;
    checks++;
    if (obs_ia.size() < 50) begin
      failures++; $display("FAIL rand_count got=%0d exp>=50", obs_ia.size());
    end
    foreach (obs_ia[i]) begin
      checks++;
      if (obs_ia[i] !== 32'(4 * i) || obs_id[i] !== mem_data(32'(4 * i))) begin
        failures++; $display("FAIL rand_inst[%0d] got=%h/%h exp=%h/%h", i, obs_ia[i], obs_id[i], 32'(4 * i), mem_data(32'(4 * i)));
      end
    end
    foreach (obs_req[i]) begin
      checks++;
      if (obs_req[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL rand_req[%0d] got=%h exp=%h", i, obs_req[i], 32'(4 * i));
      end
    end
    checks++;
    if (max_occ > 2) begin
      failures++; $display("FAIL rand_occupancy got=%0d exp<=2", max_occ);
    end
  endtask

  task automatic test_reset_midstream();
    irdy = 1'b0; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (last_inst_valid !== 1'b1) begin
      failures++; $display("FAIL mid_buffered got=%b exp=1", last_inst_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (last_req_valid !== 1'b0 || last_inst_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs req_valid=%b inst_valid=%b exp=0,0", last_req_valid, last_inst_valid);
    end
    rst = 1'b0; irdy = 1'b1;
    clear_obs();
    tick();
    checks++;
    if (last_inst_valid !== 1'b0 || last_req_valid !== 1'b1 || last_req_addr !== 32'h0) begin
      failures++; $display("FAIL mid_after_release inst_valid=%b req_valid=%b addr=%h exp=0,1,00000000",
                           last_inst_valid, last_req_valid, last_req_addr);
    end
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (obs_ia.size() == 0 || obs_ia[0] !== 32'h0) begin
      failures++; $display("FAIL mid_first_inst got=%h exp=00000000", obs_ia.size() ? obs_ia[0] : 32'hx);
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_address = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b0;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_with_rsp();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
